// File: rtl/morse_pkg.sv
// Types and constants shared by the Morse decoder and the lookup/display stage.
// Symbol encoding: bit value 1 is a dash and 0 is a dot, with the first symbol in bit 0.
package morse_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MARK = 2'd1,
        GAP  = 2'd2
    } state_t;

    localparam int MAX_SYM = 5;

    localparam logic SYM_DOT  = 1'b0;
    localparam logic SYM_DASH = 1'b1;

endpackage

// File: rtl/morse_key_decoder_if.sv
// Key/tick inputs and decoded-character strobes of the Morse decoder.
// Master is the decoder side. There is no handshake, so the slave must take every strobe.
interface morse_key_decoder_if #(
    parameter int MAX_SYM = morse_pkg::MAX_SYM
);
    logic               tick;
    logic               key;
    logic [MAX_SYM-1:0] sym_bits;
    logic [2:0]         sym_len;
    logic               char_valid;
    logic               word_gap;
    logic               overflow;

    modport master (
        input  tick,
        input  key,
        output sym_bits,
        output sym_len,
        output char_valid,
        output word_gap,
        output overflow
    );

    modport slave (
        output tick,
        output key,
        input  sym_bits,
        input  sym_len,
        input  char_valid,
        input  word_gap,
        input  overflow
    );
endinterface

// File: rtl/morse_dur_counter.sv
// Saturating tick counter with a synchronous clear. The value updates one cycle after tick.
// Clear takes priority over tick, so an edge in the same cycle as a tick yields 0.
module morse_dur_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    output logic [CNT_W-1:0] cnt
);

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && (cnt != {CNT_W{1'b1}})) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/morse_key_decoder.sv
// Converts mark/gap timing into dot/dash characters and word boundaries.
// Strobes are registered one cycle after the threshold tick, with no backpressure.
module morse_key_decoder
    import morse_pkg::*;
#(
    parameter int DASH_MIN = 2,
    parameter int CHAR_GAP = 2,
    parameter int WORD_GAP = 5,
    parameter int MAX_SYM  = morse_pkg::MAX_SYM,
    parameter int CNT_W    = 8
) (
    input  logic                clk_in,
    input  logic                rst,
    morse_key_decoder_if.master bus
);

    state_t             state;
    state_t             state_nxt;
    logic               key_q;
    logic               rise;
    logic               fall;
    logic [CNT_W-1:0]   cnt;
    logic               cnt_clr;
    logic               sym_push;
    logic               fin;
    logic               word_hit;
    logic               sym_val;
    logic [MAX_SYM-1:0] acc_bits;
    logic [2:0]         acc_len;
    logic               ovf;

    assign rise    = bus.key & ~key_q;
    assign fall    = ~bus.key & key_q;
    assign sym_val = (cnt >= CNT_W'(DASH_MIN)) ? SYM_DASH : SYM_DOT;

    morse_dur_counter #(
        .CNT_W (CNT_W)
    ) u_cnt (
        .clk_in (clk_in),
        .rst    (rst),
        .clr    (cnt_clr),
        .en     (bus.tick),
        .cnt    (cnt)
    );

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_clr   = 1'b0;
        sym_push  = 1'b0;
        fin       = 1'b0;
        word_hit  = 1'b0;
        case (state)
            IDLE: begin
                cnt_clr = 1'b1;
                if (rise) begin
                    state_nxt = MARK;
                end
            end
            MARK: begin
                if (fall) begin
                    sym_push  = 1'b1;
                    cnt_clr   = 1'b1;
                    state_nxt = GAP;
                end
            end
            GAP: begin
                // Thresholds compare the pre-tick count so they fire on the tick that reaches them.
                fin      = bus.tick && (cnt == CNT_W'(CHAR_GAP - 1));
                word_hit = bus.tick && (cnt == CNT_W'(WORD_GAP - 1));
                if (rise) begin
                    cnt_clr   = 1'b1;
                    state_nxt = MARK;
                end else if (word_hit) begin
                    cnt_clr   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: begin
                cnt_clr   = 1'b1;
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            key_q          <= 1'b0;
            acc_bits       <= '0;
            acc_len        <= '0;
            ovf            <= 1'b0;
            bus.sym_bits   <= '0;
            bus.sym_len    <= '0;
            bus.char_valid <= 1'b0;
            bus.overflow   <= 1'b0;
            bus.word_gap   <= 1'b0;
        end else begin
            key_q          <= bus.key;
            bus.char_valid <= fin & ~ovf;
            bus.overflow   <= fin & ovf;
            bus.word_gap   <= word_hit;
            if (fin) begin
                // An overflowed character is dropped, and the last good pattern stays visible.
                if (!ovf) begin
                    bus.sym_bits <= acc_bits;
                    bus.sym_len  <= acc_len;
                end
                acc_bits <= '0;
                acc_len  <= '0;
                ovf      <= 1'b0;
            end else if (sym_push) begin
                if (acc_len == 3'(MAX_SYM)) begin
                    ovf <= 1'b1;
                end else begin
                    acc_bits <= acc_bits | ({{(MAX_SYM-1){1'b0}}, sym_val} << acc_len);
                    acc_len  <= acc_len + 3'd1;
                end
            end
        end
    end

endmodule

// File: doc/morse_key_decoder.md
# morse_key_decoder

Receive-side timing decoder for the Morse translator. It samples a debounced key line and measures mark and gap lengths in time units, using a one-cycle `tick` strobe from the unit-timebase generator. Marks are classified as dot or dash and accumulated into a symbol pattern. Gaps are classified as intra-character, character end, or word end. It hands completed characters to the lookup/display stage as a pattern plus a valid strobe.

## Interface
Parameters:
- `DASH_MIN`, default 2: a mark of at least this many ticks is a dash; shorter marks are dots.
- `CHAR_GAP`, default 2: gap length in ticks that terminates a character.
- `WORD_GAP`, default 5: gap length in ticks that signals a word boundary. Must be greater than `CHAR_GAP`.
- `MAX_SYM`, default 5: maximum number of symbols per character.
- `CNT_W`, default 8: width of the duration counter.

Ports:
- `clk_in`, in, 1: system clock, single domain.
- `rst`, in, 1: asynchronous, active-high reset.
- `tick`, in, 1: time-unit strobe, one `clk_in` cycle wide.
- `key`, in, 1: synchronized, debounced key. 1 means mark (key down).
- `sym_bits`, out, `MAX_SYM`: symbol pattern. Bit 0 is the first symbol; 1 = dash, 0 = dot. Unused upper bits are 0.
- `sym_len`, out, 3: number of valid symbols, 1..`MAX_SYM`.
- `char_valid`, out, 1: one-cycle strobe; `sym_bits`/`sym_len` are valid in this cycle.
- `word_gap`, out, 1: one-cycle strobe marking a word boundary.
- `overflow`, out, 1: one-cycle strobe; the character exceeded `MAX_SYM` symbols and was discarded.

## Operation
- Key edges are detected at `clk_in` rate using one registered copy of `key`. Durations are counted in ticks.
- The counter is `CNT_W` bits wide, saturates at all-ones, and is cleared on every state change.
- The FSM has three states: IDLE, MARK, GAP.
- **IDLE:** the accumulator is empty. On a rising `key` edge, go to MARK with count 0.
- **MARK:** count ticks.
  - On a falling `key` edge, append one symbol: dash if count ≥ `DASH_MIN`, else dot. A count of 0 is a dot.
  - If `MAX_SYM` symbols are already held, set the internal `ovf` flag and drop the symbol.
  - Then go to GAP with count 0.
- **GAP:** count ticks.
  - A rising edge before the count reaches `CHAR_GAP` goes to MARK; the same character continues.
  - When a tick makes count equal `CHAR_GAP`, the character finalizes:
    - if `ovf` is set, pulse `overflow`; otherwise pulse `char_valid`;
    - then clear the accumulator and `ovf`, and stay in GAP.
  - A rising edge after finalization goes to MARK and starts a new character.
  - When a tick makes count equal `WORD_GAP`, pulse `word_gap` and go to IDLE.
- Simultaneous events:
  - Finalization tick and rising edge in the same cycle: the character finalizes, and MARK starts a new, empty character with count 0.
  - Edge and tick in the same cycle: the edge wins; the count is cleared, not incremented.
- `word_gap` fires only on the path from GAP. A long silence in IDLE never produces it, so there are no repeated word gaps.

## Timing
- Reset value of every output is 0. The FSM resets to IDLE, the accumulator to empty, and `ovf` to 0.
- Reset is honored at any point, including mid-MARK or mid-GAP. A partial character is discarded and produces no strobe.
- `char_valid`, `overflow` and `word_gap` are registered. Each asserts exactly one cycle, in the cycle after the tick that completed the gap threshold.
- `sym_bits`/`sym_len` update in the same cycle as `char_valid` and hold until the next `char_valid` or reset.
- Maximum latency from the last key release to `char_valid` is `CHAR_GAP` ticks plus 1 `clk_in` cycle.
- No handshake: the downstream consumer must accept a strobe in any cycle.

## Structure
- `morse_pkg` holds:
  - the state enum (IDLE/MARK/GAP);
  - `MAX_SYM`;
  - the symbol encoding constants `SYM_DOT = 0` and `SYM_DASH = 1`.

  The display/lookup stage shares these.
- One sub-module, `morse_dur_counter`: `CNT_W`-bit saturating counter with synchronous clear and tick enable.
- The FSM, accumulator shift register and output registers live in the top module.

## Test plan
- **'A'** (defaults): mark 1 tick, gap 1, mark 3, gap 3. Expect one `char_valid` with `sym_bits=5'b00010`, `sym_len=2`, one cycle after the 2nd gap tick.
- **'S' then silence:** three 1-tick marks with 1-tick gaps, then gap 8. Expect `char_valid` with `sym_bits=0`, `sym_len=3`, then exactly one `word_gap` after gap tick 5, then the FSM returns to IDLE with no further strobes.
- **Overflow:** six 1-tick dots. Expect one `overflow` pulse, no `char_valid`. A following 'E' (single dot) decodes as `sym_bits=0`, `sym_len=1`.
- **Simultaneous finalize and edge:** `key` rises in the same cycle as the 2nd gap tick. Expect `char_valid` for the prior character, and the new mark counted from 0 into a fresh character.
- **Saturation:** 300-tick mark with `CNT_W=8`. The counter holds at 255, no wrap, and the symbol is classified as a dash.
- **Reset mid-MARK:** assert `rst` 2 ticks into a mark. All outputs go to 0 immediately, with no strobe. After release, a dot plus gap 2 yields `sym_len=1`.
